axis_switch_1xn_pkt: RTL

//  Parametrised 1-to-NUM_M AXI-Stream demux; successor to the simple 1x2 switch.

---
 rtl/axis_switch_1xn_pkt.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axis_switch_1xn_pkt.sv
// 1-to-NUM_M AXI-Stream packet demux: route latched on the first beat of each packet,
// one registered output stage, disabled/invalid routes either dropped or stalled.
module axis_switch_1xn_pkt #(
  parameter int unsigned DATAW   = 48,
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned DROP_EN = 1,
  localparam int unsigned SELW   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int unsigned KEEPW  = DATAW / 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [SELW-1:0]          sel,
  input  logic [NUM_M-1:0]         m_en,
  input  logic [DATAW-1:0]         s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  input  logic [KEEPW-1:0]         s_axis_tstrb,
  input  logic [KEEPW-1:0]         s_axis_tkeep,
  input  logic                     s_axis_tid,
  input  logic                     s_axis_tdest,
  output logic [NUM_M*DATAW-1:0]   m_axis_tdata,
  output logic [NUM_M-1:0]         m_axis_tvalid,
  input  logic [NUM_M-1:0]         m_axis_tready,
  output logic [NUM_M-1:0]         m_axis_tuser,
  output logic [NUM_M-1:0]         m_axis_tlast,
  output logic [NUM_M*KEEPW-1:0]   m_axis_tstrb,
  output logic [NUM_M*KEEPW-1:0]   m_axis_tkeep,
  output logic [NUM_M-1:0]         m_axis_tid,
  output logic [NUM_M-1:0]         m_axis_tdest,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam bit         DROP_ON = (DROP_EN != 0);

  logic [0:0]                   r_state;
  logic [0:0]                   w_state_nxt;
  logic [SELW-1:0]              r_route;
  logic                         r_drop;
  logic                         r_active;
  logic [15:0]                  r_drop_cnt;

  logic [NUM_M-1:0]             r_m_tvalid;
  logic [NUM_M-1:0]             r_m_tuser;
  logic [NUM_M-1:0]             r_m_tlast;
  logic [NUM_M-1:0]             r_m_tid;
  logic [NUM_M-1:0]             r_m_tdest;
  logic [NUM_M-1:0][DATAW-1:0]  r_m_tdata;
  logic [NUM_M-1:0][KEEPW-1:0]  r_m_tstrb;
  logic [NUM_M-1:0][KEEPW-1:0]  r_m_tkeep;

  logic                         w_sel_in_range;
  logic                         w_sel_en;
  logic                         w_sel_ok;
  logic [SELW-1:0]              w_cur_route;
  logic                         w_cur_drop;
  logic                         w_oreg_valid;
  logic                         w_pass_ready;
  logic                         w_tready;
  logic                         w_acc;
  logic                         w_acc_pass;
  logic                         w_acc_drop;

  // Requested route is usable only if it names an existing, enabled port.
  assign w_sel_in_range = ({1'b0, sel} < (SELW+1)'(NUM_M));

  always_comb begin : sel_enable
    w_sel_en = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (sel == SELW'(i)) w_sel_en = m_en[i];
    end
  end

  assign w_sel_ok = w_sel_in_range && w_sel_en;

  // In IDLE the live select decides the route; once a packet is open it is frozen.
  always_comb begin : route_mux
    w_cur_route = r_route;
    w_cur_drop  = r_drop;
    if (r_state == ST_IDLE) begin
      w_cur_route = sel;
      w_cur_drop  = !w_sel_ok;
    end
  end

  assign w_oreg_valid = |r_m_tvalid;
  assign w_pass_ready = !w_oreg_valid || (|(r_m_tvalid & m_axis_tready));

  always_comb begin : ready_gen
    w_tready = 1'b0;
    if (r_active) begin
      if (w_cur_drop) w_tready = (r_state == ST_BUSY) || DROP_ON;
      else            w_tready = w_pass_ready;
    end
  end

  assign w_acc      = s_axis_tvalid && w_tready;
  assign w_acc_pass = w_acc && !w_cur_drop;
  assign w_acc_drop = w_acc && w_cur_drop;

  always_ff @(posedge aclk or negedge aresetn) begin : state_reg
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin : state_nxt
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc && !s_axis_tlast) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_acc && s_axis_tlast)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Route and mode captured on every first beat; held for the rest of the packet.
  always_ff @(posedge aclk or negedge aresetn) begin : route_reg
    if (!aresetn) begin
      r_route <= '0;
      r_drop  <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_acc) begin
      r_route <= sel;
      r_drop  <= !w_sel_ok;
    end
  end

  // Keeps s_axis_tready low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin : active_reg
    if (!aresetn) r_active <= 1'b0;
    else          r_active <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin : drop_reg
    if (!aresetn) begin
      r_drop_cnt <= '0;
    end else if (w_acc_drop && s_axis_tlast && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Per-port output registers: only the routed port loads; a port clears to zero on handshake.
  always_ff @(posedge aclk or negedge aresetn) begin : out_regs
    if (!aresetn) begin
      r_m_tvalid <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= '0;
      r_m_tid    <= '0;
      r_m_tdest  <= '0;
      r_m_tdata  <= '0;
      r_m_tstrb  <= '0;
      r_m_tkeep  <= '0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (w_acc_pass && (w_cur_route == SELW'(i))) begin
          r_m_tvalid[i] <= 1'b1;
          r_m_tuser[i]  <= s_axis_tuser;
          r_m_tlast[i]  <= s_axis_tlast;
          r_m_tid[i]    <= s_axis_tid;
          r_m_tdest[i]  <= s_axis_tdest;
          r_m_tdata[i]  <= s_axis_tdata;
          r_m_tstrb[i]  <= s_axis_tstrb;
          r_m_tkeep[i]  <= s_axis_tkeep;
        end else if (r_m_tvalid[i] && m_axis_tready[i]) begin
          r_m_tvalid[i] <= 1'b0;
          r_m_tuser[i]  <= 1'b0;
          r_m_tlast[i]  <= 1'b0;
          r_m_tid[i]    <= 1'b0;
          r_m_tdest[i]  <= 1'b0;
          r_m_tdata[i]  <= '0;
          r_m_tstrb[i]  <= '0;
          r_m_tkeep[i]  <= '0;
        end
      end
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tid    = r_m_tid;
  assign m_axis_tdest  = r_m_tdest;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tstrb  = r_m_tstrb;
  assign m_axis_tkeep  = r_m_tkeep;
  assign busy          = (r_state == ST_BUSY) || w_oreg_valid;
  assign drop_cnt      = r_drop_cnt;

endmodule
